// File: rtl/debouncer_bank_if.sv
// Signal bundle between the raw button/pad inputs and the debounced outputs
// that feed ImageOutput.
interface debouncer_bank_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] io_in;
  logic [1:0]          io_mode;
  logic [CHANNELS-1:0] io_repeatEn;
  logic [CHANNELS-1:0] io_out;
  logic [CHANNELS-1:0] io_level;
  logic                io_any;

  modport master (
    output io_in, io_mode, io_repeatEn,
    input  io_out, io_level, io_any
  );

  modport slave (
    input  io_in, io_mode, io_repeatEn,
    output io_out, io_level, io_any
  );
endinterface

// File: rtl/debouncer_bank.sv
// N-channel button debouncer: a 2-flop synchroniser, a stability window and
// edge/level output modes per channel, with optional hold-to-repeat pulses.
module debouncer_bank #(
  parameter int CHANNELS      = 8,
  parameter int STABLE_CYCLES = 252000,
  parameter int REPEAT_DELAY  = 12600000,
  parameter int REPEAT_PERIOD = 2520000,
  parameter int ACTIVE_LOW    = 0
) (
  input logic             clock,
  input logic             reset,
  debouncer_bank_if.slave io
);

  localparam int REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_MAX + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] REPEAT_SAT  = RW'(REPEAT_MAX);

  typedef enum logic [1:0] {
    MODE_PRESS   = 2'd0,
    MODE_RELEASE = 2'd1,
    MODE_BOTH    = 2'd2,
    MODE_LEVEL   = 2'd3
  } mode_e;

  mode_e               mode;
  logic [CHANNELS-1:0] pin;
  logic [CHANNELS-1:0] s1, s2;
  logic [CHANNELS-1:0] stable, stable_d;
  logic [CHANNELS-1:0] out, out_d;
  logic [CHANNELS-1:0] rise, fall;
  logic [CHANNELS-1:0] rep_on, rep_hit;
  logic [CHANNELS-1:0] rep_periodic, rep_periodic_d;
  logic [SW-1:0]       cnt    [CHANNELS];
  logic [SW-1:0]       cnt_d  [CHANNELS];
  logic [RW-1:0]       rcnt   [CHANNELS];
  logic [RW-1:0]       rcnt_d [CHANNELS];
  logic                edge_press, edge_release;

  assign pin  = (ACTIVE_LOW != 0) ? ~io.io_in : io.io_in;
  assign mode = mode_e'(io.io_mode);

  // Per-channel stability window, edge detection, repeat timing and output select.
  always_comb begin
    stable_d       = stable;
    out_d          = '0;
    rise           = '0;
    fall           = '0;
    rep_on         = '0;
    rep_hit        = '0;
    rep_periodic_d = rep_periodic;
    cnt_d          = cnt;
    rcnt_d         = rcnt;
    edge_press     = (mode == MODE_PRESS) || (mode == MODE_BOTH);
    edge_release   = (mode == MODE_RELEASE) || (mode == MODE_BOTH);
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (s2[i] != stable[i]) begin
        if (cnt[i] == STABLE_LAST) begin
          stable_d[i] = s2[i];
          cnt_d[i]    = '0;
          rise[i]     = s2[i];
          fall[i]     = ~s2[i];
        end else begin
          cnt_d[i] = cnt[i] + SW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end

      // Repeat timing runs whenever the button is held and enabled; the mode
      // only gates whether the resulting ticks reach the output. The release
      // edge itself already counts as not held.
      rep_on[i]  = stable[i] & io.io_repeatEn[i] & ~fall[i];
      rep_hit[i] = rep_on[i] &&
                   (rcnt[i] == (rep_periodic[i] ? PERIOD_LAST : DELAY_LAST));
      if (!rep_on[i]) begin
        rcnt_d[i]         = '0;
        rep_periodic_d[i] = 1'b0;
      end else if (rep_hit[i]) begin
        rcnt_d[i]         = '0;
        rep_periodic_d[i] = 1'b1;
      end else if (rcnt[i] != REPEAT_SAT) begin
        rcnt_d[i] = rcnt[i] + RW'(1);
      end

      if (mode == MODE_LEVEL) begin
        out_d[i] = stable_d[i];
      end else begin
        out_d[i] = (rise[i] & edge_press) | (fall[i] & edge_release) |
                   (rep_hit[i] & edge_press);
      end
    end
  end

  // Synchroniser stages and all per-channel state.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1           <= '0;
      s2           <= '0;
      stable       <= '0;
      out          <= '0;
      rep_periodic <= '0;
      cnt          <= '{default: '0};
      rcnt         <= '{default: '0};
    end else begin
      s1           <= pin;
      s2           <= s1;
      stable       <= stable_d;
      out          <= out_d;
      rep_periodic <= rep_periodic_d;
      cnt          <= cnt_d;
      rcnt         <= rcnt_d;
    end
  end

  assign io.io_out   = out;
  assign io.io_level = stable;
  assign io.io_any   = |out;

endmodule
